// File: rtl/ov7670_pixel_capture.sv
// rtl/ov7670_pixel_capture.sv - OV7670 byte-stream to pixel capture with frame/line tracking
// Inputs are registered once (S1); the FSM only arms on a full VSYNC high-then-low sequence.
module ov7670_pixel_capture #(
  parameter int BYTES_PER_PIX = 2,
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int DECIM         = 1,
  localparam int PW = 8 * BYTES_PER_PIX,
  localparam int XW = (H_ACTIVE / DECIM > 1) ? $clog2(H_ACTIVE / DECIM) : 1,
  localparam int YW = (V_ACTIVE / DECIM > 1) ? $clog2(V_ACTIVE / DECIM) : 1
) (
  input  logic          PCLK,
  input  logic          RESET_N,
  input  logic          ENABLE,
  input  logic          VSYNC,
  input  logic          HREF,
  input  logic [7:0]    D,
  output logic [PW-1:0] PIXEL_DATA,
  output logic          PIXEL_VALID,
  output logic [XW-1:0] X_ADDR,
  output logic [YW-1:0] Y_ADDR,
  output logic          FRAME_START,
  output logic          FRAME_DONE,
  output logic          LINE_ERR,
  output logic [7:0]    FRAME_CNT
);

  localparam int CW = 16;
  localparam int DSH = $clog2(DECIM);
  localparam logic [CW-1:0] DMASK = CW'(DECIM - 1);
  localparam logic [CW-1:0] H_LIM = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_LIM = CW'(V_ACTIVE);
  localparam logic          LAST_PH = (BYTES_PER_PIX == 2);

  typedef enum logic [1:0] {SYNC, WAIT_FRAME, ACTIVE} state_t;

  state_t        state_q, state_d;
  logic          s1_vsync_q, s1_href_q;
  logic [7:0]    s1_d_q;
  logic          vsync_prev_q, href_prev_q;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          phase_q, phase_d;
  logic [PW-1:0] asm_q, asm_d, pix_w;
  logic [PW-1:0] pix_data_q, pix_data_d;
  logic          pix_valid_q, pix_valid_d;
  logic [XW-1:0] x_addr_q, x_addr_d;
  logic [YW-1:0] y_addr_q, y_addr_d;
  logic          fs_q, fs_d, fd_q, fd_d, line_err_q, line_err_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d;
  logic          vsync_rise, vsync_fall, href_fall;

  // Counters saturate so very long lines/frames never alias back into the active window.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  assign vsync_rise = s1_vsync_q & ~vsync_prev_q;
  assign vsync_fall = ~s1_vsync_q & vsync_prev_q;
  assign href_fall  = ~s1_href_q & href_prev_q;
  assign pix_w      = (asm_q << 8) | PW'(s1_d_q);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    phase_d     = phase_q;
    asm_d       = asm_q;
    pix_data_d  = pix_data_q;
    pix_valid_d = 1'b0;
    x_addr_d    = x_addr_q;
    y_addr_d    = y_addr_q;
    fs_d        = 1'b0;
    fd_d        = 1'b0;
    line_err_d  = line_err_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      SYNC: if (s1_vsync_q && ENABLE) state_d = WAIT_FRAME;
      WAIT_FRAME: begin
        if (vsync_fall) begin
          state_d    = ACTIVE;
          fs_d       = 1'b1;
          x_d        = '0;
          y_d        = '0;
          phase_d    = 1'b0;
          line_err_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (s1_href_q) begin
          asm_d = pix_w;
          if (phase_q == LAST_PH) begin
            phase_d = 1'b0;
            x_d     = sat_inc(x_q);
            if (x_q < H_LIM && y_q < V_LIM && (x_q & DMASK) == '0 && (y_q & DMASK) == '0) begin
              pix_valid_d = 1'b1;
              pix_data_d  = pix_w;
              x_addr_d    = XW'(x_q >> DSH);
              y_addr_d    = YW'(y_q >> DSH);
            end
          end else begin
            phase_d = ~phase_q;
          end
        end else begin
          phase_d = 1'b0;
          if (href_fall) begin
            if (x_q != H_LIM || phase_q != 1'b0) line_err_d = 1'b1;
            x_d = '0;
            y_d = sat_inc(y_q);
          end
        end
        // Frame end is evaluated after the line check so a coincident HREF fall is still judged.
        if (vsync_rise) begin
          fd_d        = 1'b1;
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = ENABLE ? WAIT_FRAME : SYNC;
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge PCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= SYNC;
      s1_vsync_q   <= 1'b0;
      s1_href_q    <= 1'b0;
      s1_d_q       <= '0;
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      phase_q      <= 1'b0;
      asm_q        <= '0;
      pix_data_q   <= '0;
      pix_valid_q  <= 1'b0;
      x_addr_q     <= '0;
      y_addr_q     <= '0;
      fs_q         <= 1'b0;
      fd_q         <= 1'b0;
      line_err_q   <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      s1_vsync_q   <= VSYNC;
      s1_href_q    <= HREF;
      s1_d_q       <= D;
      vsync_prev_q <= s1_vsync_q;
      href_prev_q  <= s1_href_q;
      x_q          <= x_d;
      y_q          <= y_d;
      phase_q      <= phase_d;
      asm_q        <= asm_d;
      pix_data_q   <= pix_data_d;
      pix_valid_q  <= pix_valid_d;
      x_addr_q     <= x_addr_d;
      y_addr_q     <= y_addr_d;
      fs_q         <= fs_d;
      fd_q         <= fd_d;
      line_err_q   <= line_err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign PIXEL_DATA  = pix_data_q;
  assign PIXEL_VALID = pix_valid_q;
  assign X_ADDR      = x_addr_q;
  assign Y_ADDR      = y_addr_q;
  assign FRAME_START = fs_q;
  assign FRAME_DONE  = fd_q;
  assign LINE_ERR    = line_err_q;
  assign FRAME_CNT   = frame_cnt_q;

endmodule
